// File: rtl/hdlc_tx_ctrl.sv
// ============================================================================
// hdlc_tx_ctrl -- HDLC transmit frame sequencer
//
// Takes a frame request (byte count) and fetches the payload bytes from the
// Tx buffer with a one-cycle read strobe. It then serialises the frame LSB
// first, one bit per clock:
//   - start flag;
//   - payload with zero insertion (a 0 after every five consecutive 1s);
//   - end flag.
// On request it replaces the frame with an abort sequence (0 followed by
// seven 1s).
//
// Every output is a register. The bit chosen while the FSM sits in a given
// state cycle therefore appears on Tx one clock later. The one exception is
// the abort edge, which replaces the outgoing bit with the leading 0 of the
// abort sequence.
//
// Optional build macro:
//   HDLC_TX_IDLE_FLAGS_EN -- when defined, the idle line carries continuous
//                            flags. An accepted request waits for the
//                            current idle flag to complete. When undefined,
//                            the idle line is held at 1.
//
// Ports:
//   Clk             in   system clock, rising edge
//   Rst             in   asynchronous reset, active low
//   Tx_Enable       in   frame request, only honoured in IDLE
//   Tx_FrameSize    in   payload byte count (1..MAX_FRAME_BYTES accepted)
//   Tx_AbortFrame   in   abort request (START_FLAG / DATA only)
//   Tx_Data         in   buffer read data, valid the cycle after Tx_RdBuff
//   Tx_RdBuff       out  one-cycle read strobe to the Tx buffer
//   Tx              out  serial line
//   Tx_ValidFrame   out  high while flags + payload are on the line
//   Tx_AbortedTrans out  sticky: last frame was aborted
//   Tx_Done         out  one-cycle pulse after a normally completed frame
// ============================================================================
module hdlc_tx_ctrl #(
    parameter int         MAX_FRAME_BYTES = 128,
    parameter logic [7:0] FLAG_PATTERN    = 8'h7E
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tx_Enable,
    input  logic [7:0] Tx_FrameSize,
    input  logic       Tx_AbortFrame,
    input  logic [7:0] Tx_Data,
    output logic       Tx_RdBuff,
    output logic       Tx,
    output logic       Tx_ValidFrame,
    output logic       Tx_AbortedTrans,
    output logic       Tx_Done
);

    localparam logic [7:0] MAX_BYTES = 8'(MAX_FRAME_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_END,
        S_ABORT
    } state_t;

    state_t     state_q;
    logic [2:0] idx_q;        // flag / abort / idle-flag bit index
    logic [2:0] bit_q;        // payload bit counter within the current byte
    logic [2:0] ones_q;       // consecutive 1s sent in DATA
    logic [7:0] bytes_q;      // bytes remaining, including the one in shift_q
    logic [7:0] shift_q;
    logic [7:0] hold_q;
    logic       cap_q;        // Tx_Data is valid this cycle (strobe was last cycle)
    logic       tail_q;       // last payload bit sent, stuffed 0 still owed
    logic       end_last_q;   // final end-flag bit was just scheduled
    logic       rd_q;
    logic       tx_q;
    logic       valid_q;
    logic       aborted_q;
    logic       done_q;
`ifdef HDLC_TX_IDLE_FLAGS_EN
    logic       pend_q;       // accepted request waiting for a flag boundary
`endif

    logic req_ok;
    assign req_ok = Tx_Enable && (Tx_FrameSize != 8'd0) && (Tx_FrameSize <= MAX_BYTES);

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= S_IDLE;
            idx_q      <= 3'd0;
            bit_q      <= 3'd0;
            ones_q     <= 3'd0;
            bytes_q    <= 8'd0;
            shift_q    <= 8'd0;
            hold_q     <= 8'd0;
            cap_q      <= 1'b0;
            tail_q     <= 1'b0;
            end_last_q <= 1'b0;
            rd_q       <= 1'b0;
            tx_q       <= 1'b1;
            valid_q    <= 1'b0;
            aborted_q  <= 1'b0;
            done_q     <= 1'b0;
`ifdef HDLC_TX_IDLE_FLAGS_EN
            pend_q     <= 1'b0;
`endif
        end else begin
            rd_q       <= 1'b0;
            cap_q      <= rd_q;
            done_q     <= end_last_q;
            end_last_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
`ifdef HDLC_TX_IDLE_FLAGS_EN
                    tx_q  <= FLAG_PATTERN[idx_q];
                    idx_q <= idx_q + 3'd1;
                    if (req_ok && !pend_q) begin
                        pend_q    <= 1'b1;
                        aborted_q <= 1'b0;
                        bytes_q   <= Tx_FrameSize;
                    end
                    // idx_q wraps to 0, so START_FLAG begins on a flag boundary
                    if ((pend_q || req_ok) && idx_q == 3'd7) begin
                        pend_q  <= 1'b0;
                        state_q <= S_START;
                    end
`else
                    tx_q <= 1'b1;
                    if (req_ok) begin
                        state_q   <= S_START;
                        idx_q     <= 3'd0;
                        aborted_q <= 1'b0;
                        bytes_q   <= Tx_FrameSize;
                    end
`endif
                end

                S_START, S_DATA: begin
                    if (Tx_AbortFrame) begin
                        // Leading 0 of the abort sequence goes out on this edge;
                        // any captured byte and outstanding fetch are dropped.
                        state_q   <= S_ABORT;
                        idx_q     <= 3'd0;
                        tx_q      <= 1'b0;
                        valid_q   <= 1'b0;
                        aborted_q <= 1'b1;
                        rd_q      <= 1'b0;
                        cap_q     <= 1'b0;
                    end else if (state_q == S_START) begin
                        tx_q    <= FLAG_PATTERN[idx_q];
                        valid_q <= 1'b1;
                        idx_q   <= idx_q + 3'd1;
                        // Strobe visible at idx 6, data arrives during idx 7
                        rd_q    <= (idx_q == 3'd5);
                        if (idx_q == 3'd7) begin
                            shift_q <= Tx_Data;
                            bit_q   <= 3'd0;
                            ones_q  <= 3'd0;
                            tail_q  <= 1'b0;
                            state_q <= S_DATA;
                        end
                    end else begin
                        valid_q <= 1'b1;
                        if (cap_q) begin
                            hold_q <= Tx_Data;
                        end
                        if (ones_q == 3'd5) begin
                            // Stuffed 0: shift register and bit counter hold
                            tx_q   <= 1'b0;
                            ones_q <= 3'd0;
                            if (tail_q) begin
                                state_q <= S_END;
                                idx_q   <= 3'd0;
                            end
                        end else begin
                            tx_q    <= shift_q[0];
                            ones_q  <= shift_q[0] ? ones_q + 3'd1 : 3'd0;
                            shift_q <= {1'b0, shift_q[7:1]};
                            bit_q   <= bit_q + 3'd1;
                            // Prefetch: strobe is visible while bit 6 goes out
                            if (bit_q == 3'd5 && bytes_q > 8'd1) begin
                                rd_q <= 1'b1;
                            end
                            if (bit_q == 3'd7) begin
                                if (bytes_q > 8'd1) begin
                                    // Data may still be on the bus if no stuff bit delayed bit 7
                                    shift_q <= cap_q ? Tx_Data : hold_q;
                                    bytes_q <= bytes_q - 8'd1;
                                end else if (shift_q[0] && ones_q == 3'd4) begin
                                    tail_q <= 1'b1;
                                end else begin
                                    state_q <= S_END;
                                    idx_q   <= 3'd0;
                                end
                            end
                        end
                    end
                end

                S_END: begin
                    tx_q    <= FLAG_PATTERN[idx_q];
                    valid_q <= 1'b1;
                    idx_q   <= idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_q    <= S_IDLE;
                        end_last_q <= 1'b1;
                    end
                end

                S_ABORT: begin
                    // Seven 1s follow the leading 0 emitted on entry
                    tx_q    <= 1'b1;
                    valid_q <= 1'b0;
                    idx_q   <= idx_q + 3'd1;
                    if (idx_q == 3'd6) begin
                        state_q <= S_IDLE;
                        idx_q   <= 3'd0;
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    idx_q   <= 3'd0;
                end
            endcase
        end
    end

    assign Tx_RdBuff       = rd_q;
    assign Tx              = tx_q;
    assign Tx_ValidFrame   = valid_q;
    assign Tx_AbortedTrans = aborted_q;
    assign Tx_Done         = done_q;

endmodule

// File: tb/tb_hdlc_tx_ctrl.sv
module tb_hdlc_tx_ctrl;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       Tx_Enable;
    logic [7:0] Tx_FrameSize;
    logic       Tx_AbortFrame;
    logic [7:0] Tx_Data = 8'hC3;
    logic       Tx_RdBuff;
    logic       Tx;
    logic       Tx_ValidFrame;
    logic       Tx_AbortedTrans;
    logic       Tx_Done;

    hdlc_tx_ctrl dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Tx_Enable      (Tx_Enable),
        .Tx_FrameSize   (Tx_FrameSize),
        .Tx_AbortFrame  (Tx_AbortFrame),
        .Tx_Data        (Tx_Data),
        .Tx_RdBuff      (Tx_RdBuff),
        .Tx             (Tx),
        .Tx_ValidFrame  (Tx_ValidFrame),
        .Tx_AbortedTrans(Tx_AbortedTrans),
        .Tx_Done        (Tx_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic tx;
        logic valid;
        logic done;
        logic ab;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] byte_q[$];        // Tx buffer contents served on strobes
    logic [7:0] frame_b[4];
    int         checks = 0;
    int         errors = 0;
    logic       chk_en = 1'b0;
    int         rd_count = 0;
    int         served = 0;
    int         dn_count = 0;
    int         vcount = 0;
    logic [63:0] line_sr = 64'd0;
    int         exp_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Expected line for one frame: start flag, zero-inserted payload, end flag.
    // abort_j >= 0: the abort replaces line bit abort_j onwards.
    task automatic push_frame(input int n, input int abort_j);
        logic       bits[$];
        logic [7:0] flag_v;
        int         ones;
        flag_v = 8'h7E;
        ones = 0;
        for (int i = 0; i < 8; i++) bits.push_back(flag_v[i]);
        for (int by = 0; by < n; by++) begin
            for (int bi = 0; bi < 8; bi++) begin
                logic b;
                b = frame_b[by][bi];
                bits.push_back(b);
                if (b) begin
                    ones++;
                    if (ones == 5) begin
                        bits.push_back(1'b0);
                        ones = 0;
                    end
                end else begin
                    ones = 0;
                end
            end
        end
        for (int i = 0; i < 8; i++) bits.push_back(flag_v[i]);
        exp_len = bits.size();
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        if (abort_j < 0) begin
            foreach (bits[i]) exp_q.push_back('{bits[i], 1'b1, 1'b0, 1'b0});
            exp_q.push_back('{1'b1, 1'b0, 1'b1, 1'b0});
        end else begin
            for (int i = 0; i < abort_j; i++) exp_q.push_back('{bits[i], 1'b1, 1'b0, 1'b0});
            exp_q.push_back('{1'b0, 1'b0, 1'b0, 1'b1});
            for (int i = 0; i < 7; i++) exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b1});
        end
    endtask

    task automatic load_buf(input int n);
        byte_q.delete();
        for (int i = 0; i < n; i++) byte_q.push_back(frame_b[i]);
    endtask

    task automatic request(input logic [7:0] size);
        @(posedge Clk); #1;
        Tx_Enable = 1'b1;
        Tx_FrameSize = size;
        @(posedge Clk); #1;
        Tx_Enable = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge Clk);
        check({name, "_timeout"}, 32'(exp_q.size()), 32'd0);
        repeat (4) @(posedge Clk);
        #1;
    endtask

    // Per-cycle compare against the model stream, plus line monitors
    logic last_ab = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge Clk);
            if (Rst) begin
                if (Tx_RdBuff) rd_count++;
                if (Tx_Done) dn_count++;
                if (Tx_ValidFrame) begin
                    vcount++;
                    line_sr = {line_sr[62:0], Tx};
                end
            end
            if (chk_en) begin
                if (exp_q.size() != 0) e = exp_q.pop_front();
                else e = '{1'b1, 1'b0, 1'b0, last_ab};
                last_ab = e.ab;
                check("tx", {31'd0, Tx}, {31'd0, e.tx});
                check("valid", {31'd0, Tx_ValidFrame}, {31'd0, e.valid});
                check("done", {31'd0, Tx_Done}, {31'd0, e.done});
                check("aborted", {31'd0, Tx_AbortedTrans}, {31'd0, e.ab});
            end
        end
    end

    // Tx buffer: data valid for exactly the cycle after the strobe, junk otherwise
    initial begin
        forever begin
            @(posedge Clk);
            #1;
            if (rd_count > served) begin
                served++;
                Tx_Data = (byte_q.size() != 0) ? byte_q.pop_front() : 8'hC3;
            end else begin
                Tx_Data = 8'hC3;
            end
        end
    end

    int rd0, v0, dn0;

    initial begin
        Rst = 1'b0;
        Tx_Enable = 1'b0;
        Tx_FrameSize = 8'd0;
        Tx_AbortFrame = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        check("rst_tx", {31'd0, Tx}, 32'd1);
        check("rst_valid", {31'd0, Tx_ValidFrame}, 32'd0);
        check("rst_rd", {31'd0, Tx_RdBuff}, 32'd0);
        check("rst_ab", {31'd0, Tx_AbortedTrans}, 32'd0);
        check("rst_done", {31'd0, Tx_Done}, 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;
        chk_en = 1'b1;

        // Frame 2 bytes: 0x00, 0x55
        frame_b = '{8'h00, 8'h55, 8'h00, 8'h00};
        load_buf(2);
        rd0 = rd_count; v0 = vcount; dn0 = dn_count;
        request(8'd2);
        push_frame(2, -1);
        drain("f2");
        check("f2_model_len", 32'(exp_len), 32'd32);
        check("f2_line", line_sr[31:0], 32'b01111110_00000000_10101010_01111110);
        check("f2_valid_len", 32'(vcount - v0), 32'd32);
        check("f2_rd", 32'(rd_count - rd0), 32'd2);
        check("f2_done", 32'(dn_count - dn0), 32'd1);
        $display("txn f2: size 2 bytes 00 55, %0d valid cycles", vcount - v0);

        // Frame 1 byte 0xFF: stuffed 0 after five 1s
        frame_b = '{8'hFF, 8'h00, 8'h00, 8'h00};
        load_buf(1);
        rd0 = rd_count; v0 = vcount; dn0 = dn_count;
        request(8'd1);
        push_frame(1, -1);
        drain("fff");
        check("ff_model_len", 32'(exp_len), 32'd25);
        check("ff_line", {7'd0, line_sr[24:0]}, {7'd0, 25'b01111110_111110111_01111110});
        check("ff_valid_len", 32'(vcount - v0), 32'd25);
        check("ff_rd", 32'(rd_count - rd0), 32'd1);
        $display("txn ff: size 1 byte FF, %0d valid cycles", vcount - v0);

        // Abort at the 3rd data bit of byte 0
        frame_b = '{8'h11, 8'h22, 8'h33, 8'h44};
        load_buf(4);
        rd0 = rd_count; dn0 = dn_count;
        request(8'd4);
        push_frame(4, 10);
        repeat (10) @(posedge Clk);
        #1;
        Tx_AbortFrame = 1'b1;
        @(posedge Clk); #1;
        Tx_AbortFrame = 1'b0;
        drain("abort");
        check("abort_rd_max", {31'd0, (rd_count - rd0) <= 2}, 32'd1);
        check("abort_rd_min", {31'd0, (rd_count - rd0) >= 1}, 32'd1);
        check("abort_no_done", 32'(dn_count - dn0), 32'd0);
        $display("txn abort: size 4 aborted, %0d strobes", rd_count - rd0);

        // Size 0 and 129 are ignored; abort flag stays set
        rd0 = rd_count; v0 = vcount;
        request(8'd0);
        repeat (12) @(posedge Clk);
        request(8'd129);
        repeat (12) @(posedge Clk);
        #1;
        check("ign_rd", 32'(rd_count - rd0), 32'd0);
        check("ign_valid", 32'(vcount - v0), 32'd0);
        $display("txn ignore: sizes 0 and 129 rejected");

        // Enable held during frame, abort during END_FLAG: both ignored
        frame_b = '{8'h00, 8'h55, 8'h00, 8'h00};
        load_buf(2);
        rd0 = rd_count; v0 = vcount; dn0 = dn_count;
        @(posedge Clk); #1;
        Tx_Enable = 1'b1;
        Tx_FrameSize = 8'd2;
        @(posedge Clk); #1;
        push_frame(2, -1);
        repeat (20) @(posedge Clk);
        #1;
        Tx_Enable = 1'b0;
        repeat (5) @(posedge Clk);
        #1;
        Tx_AbortFrame = 1'b1;
        repeat (5) @(posedge Clk);
        #1;
        Tx_AbortFrame = 1'b0;
        drain("hold");
        check("hold_valid_len", 32'(vcount - v0), 32'd32);
        check("hold_done", 32'(dn_count - dn0), 32'd1);
        check("hold_rd", 32'(rd_count - rd0), 32'd2);
        $display("txn hold: enable held and late abort ignored");

        // Async reset mid-DATA, then a 0x7E frame
        frame_b = '{8'h00, 8'h00, 8'h00, 8'h00};
        load_buf(3);
        request(8'd3);
        push_frame(3, -1);
        repeat (11) @(posedge Clk);
        @(negedge Clk);
        chk_en = 1'b0;
        check("pre_rst_valid", {31'd0, Tx_ValidFrame}, 32'd1);
        check("pre_rst_tx", {31'd0, Tx}, 32'd0);
        #2;
        Rst = 1'b0;
        #1;
        check("arst_tx", {31'd0, Tx}, 32'd1);
        check("arst_valid", {31'd0, Tx_ValidFrame}, 32'd0);
        check("arst_rd", {31'd0, Tx_RdBuff}, 32'd0);
        check("arst_done", {31'd0, Tx_Done}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Rst = 1'b1;
        @(posedge Clk); #1;
        exp_q.push_back('{1'b1, 1'b0, 1'b0, 1'b0});
        chk_en = 1'b1;
        frame_b = '{8'h7E, 8'h00, 8'h00, 8'h00};
        load_buf(1);
        rd0 = rd_count; v0 = vcount;
        request(8'd1);
        push_frame(1, -1);
        drain("f7e");
        check("7e_line", {7'd0, line_sr[24:0]}, {7'd0, 25'b01111110_011111010_01111110});
        check("7e_valid_len", 32'(vcount - v0), 32'd25);
        check("7e_rd", 32'(rd_count - rd0), 32'd1);
        $display("txn reset: frame 7E after async reset, %0d valid cycles", vcount - v0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hdlc_tx_ctrl.md
Name: hdlc_tx_ctrl

Overview:
Transmit-side frame sequencer for the HDLC link. It takes a frame request (byte count) and fetches bytes from the Tx buffer with a read-strobe handshake. It serialises the frame onto Tx, LSB first, one bit per Clk: start flag, zero-inserted data, end flag. It also generates the abort pattern on request and drives the Tx_ValidFrame / Tx_AbortedTrans status seen by the assertion bench.

Parameters:
MAX_FRAME_BYTES, 128, largest accepted Tx_FrameSize (1..255)
FLAG_PATTERN, 8'h7E, flag byte sent for start/end flag, LSB first (0,1,1,1,1,1,1,0)

Ports:
Clk  in  1  system clock, all logic on rising edge
Rst  in  1  asynchronous reset, active-low
Tx_Enable  in  1  frame request, sampled in IDLE only
Tx_FrameSize  in  8  byte count, sampled with Tx_Enable
Tx_AbortFrame  in  1  abort request, level-sampled each cycle
Tx_Data  in  8  buffer read data, valid the cycle after Tx_RdBuff
Tx_RdBuff  out  1  one-cycle read strobe to Tx buffer
Tx  out  1  serial line, registered
Tx_ValidFrame  out  1  high while a frame (flags + data) is on the line
Tx_AbortedTrans  out  1  sticky: last frame was aborted
Tx_Done  out  1  one-cycle pulse, frame completed normally

Behaviour:
- Reset (Rst=0, async): state IDLE; Tx=1; Tx_RdBuff, Tx_ValidFrame, Tx_AbortedTrans, Tx_Done=0; counters and shift/hold registers cleared.
- States: IDLE, START_FLAG, DATA, END_FLAG, ABORT. All outputs registered.
- IDLE:
  - Tx=1.
  - Tx_Enable=1 with 1<=Tx_FrameSize<=MAX_FRAME_BYTES -> START_FLAG at next edge; Tx_AbortedTrans cleared; remaining-byte counter loaded.
  - Size 0 or >MAX: request ignored, no strobe.
  - Tx_Enable outside IDLE is ignored.
- START_FLAG:
  - 8 cycles, bit index 0..7, Tx = FLAG_PATTERN[idx], Tx_ValidFrame=1.
  - Tx_RdBuff pulses at idx 6; Tx_Data captured at idx 7 into the shift register -> DATA.
- DATA:
  - Tx = shift[0]; shift right each non-stuff cycle; 3-bit bit counter.
  - Ones counter counts consecutive 1s sent in DATA and resets on each 0 sent.
  - After the 5th consecutive 1, the next cycle sends a stuffed 0: shift and bit counter hold, ones counter resets.
  - A stuffed 0 is still sent when the 5th 1 is the last data bit, before END_FLAG.
  - Prefetch: when bit counter == 6 (non-stuff cycle) and bytes remaining > 1, Tx_RdBuff pulses once. Tx_Data is captured next cycle into the hold register and loaded into shift after bit 7. Each byte therefore gets exactly one strobe.
  - After bit 7 of the last byte (plus any pending stuff bit) -> END_FLAG.
- END_FLAG:
  - 8 cycles of FLAG_PATTERN, Tx_ValidFrame=1, Tx_AbortFrame ignored.
  - Then IDLE with Tx_Done=1 for 1 cycle and Tx_ValidFrame=0.
- Abort:
  - Tx_AbortFrame=1 in START_FLAG or DATA -> ABORT at next edge. Tx_ValidFrame=0 and Tx_AbortedTrans=1 from that edge.
  - ABORT sends 0 then 1 for 7 cycles (8 cycles), then IDLE.
  - No further Tx_RdBuff and no Tx_Done; an in-flight captured byte is discarded.
  - Tx_AbortedTrans holds until the next accepted Tx_Enable.
  - Tx_AbortFrame in IDLE, END_FLAG or ABORT: no effect.
- Latency: Tx_Enable sampled at edge k -> first flag bit on Tx after edge k+1.
- Frame length on line (no abort) = 16 + 8*N + stuffed bits cycles of Tx_ValidFrame=1.

Optional Feature:
HDLC_TX_IDLE_FLAGS_EN
- Defined: IDLE transmits FLAG_PATTERN continuously (8-bit rotation, Tx_ValidFrame=0). A request accepted in IDLE waits for the current idle flag to finish. START_FLAG then follows directly on a flag boundary. After ABORT, idle flags restart at bit 0.
- Undefined: IDLE drives Tx=1 and START_FLAG begins the edge after the request.

Test Plan:
- Tx_FrameSize=2, bytes 0x00,0x55 -> Tx = 01111110 00000000 10101010 01111110; Tx_ValidFrame=1 for 32 cycles; exactly 2 Tx_RdBuff pulses; Tx_Done one pulse after the last flag bit.
- Tx_FrameSize=1, byte 0xFF -> data bits 1,1,1,1,1,0,1,1,1; Tx_ValidFrame=1 for 25 cycles; no 6 consecutive 1s inside the frame.
- Tx_FrameSize=4, Tx_AbortFrame pulsed at 3rd data bit of byte 0 -> next cycles Tx = 0,1,1,1,1,1,1,1; Tx_ValidFrame=0; Tx_AbortedTrans=1; at most 2 Tx_RdBuff pulses; no Tx_Done; next Tx_Enable clears Tx_AbortedTrans.
- Tx_FrameSize=0, then 129 -> both ignored: Tx stays 1, no Tx_RdBuff, Tx_ValidFrame stays 0.
- Rst low mid-DATA -> outputs reach reset values without a clock edge; after release, a Tx_FrameSize=1 frame (byte 0x7E) transmits correctly with one stuffed 0.
- Tx_Enable held during a frame and Tx_AbortFrame during END_FLAG -> both ignored, frame completes, single Tx_Done.
